// File: rtl/ifu_pkg.sv
// ifu_pkg: shared definitions for the instruction fetch front end.
//   OPC_BRANCH / OPC_JAL : major opcodes, compared against inst[6:2]
//   fq_entry_t           : one fetch queue entry {pc, inst, pred}
//   imm_b / imm_j        : sign-extended B-type and J-type immediates
package ifu_pkg;

  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } fq_entry_t;

  function automatic logic signed [31:0] imm_b(input logic [31:0] inst);
    imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic signed [31:0] imm_j(input logic [31:0] inst);
    imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/ifu_sync_fifo.sv
// ifu_sync_fifo: synchronous FIFO of DEPTH entries of type T.
//   clock, reset : clock, synchronous active-high reset (clears all entries)
//   push, data   : write data at the tail
//   pop          : remove the head
//   flush        : empty the queue; wins over push and pop
//   head         : entry at the head (combinational read)
//   count        : number of stored entries
//   full, empty  : status flags derived from count
module ifu_sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  T                         data,
  input  logic                     pop,
  input  logic                     flush,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // When full, push and pop target the same slot; the head was already
      // consumed combinationally this cycle, so overwriting it is safe.
      if (push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: instruction fetch front end with a DEPTH-entry queue.
//   clock, reset         : clock, synchronous active-high reset
//   fetch_addr           : PC presented to the instruction cache
//   cache_hit/cache_inst : cache response for fetch_addr this cycle
//   jump_flush/jump_dnpc : EXU redirect
//   cs_flush/cs_dnpc     : CSR/trap redirect, higher priority than EXU
//   out_valid/out_ready  : head handshake towards decode
//   out_pc/out_inst/out_pred : head entry contents
//   occupancy            : number of queued entries
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter bit          PRED_JAL = 1'b1,
  parameter bit          PRED_BR  = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic [31:0]            fetch_addr,
  input  logic                   cache_hit,
  input  logic [31:0]            cache_inst,
  input  logic                   jump_flush,
  input  logic [31:0]            jump_dnpc,
  input  logic                   cs_flush,
  input  logic [31:0]            cs_dnpc,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_inst,
  output logic                   out_pred,
  output logic [$clog2(DEPTH):0] occupancy
);

  logic        flush;
  logic [31:0] dnpc;
  logic        pending;
  logic [31:0] dnpc_r;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic        pred;
  logic signed [31:0] pred_off;
  logic [31:0] next_pc;
  fq_entry_t   push_entry;
  fq_entry_t   head_entry;

  assign flush = cs_flush | jump_flush;
  assign dnpc  = cs_flush ? cs_dnpc : jump_dnpc;

  assign out_valid = ~empty & ~flush;
  assign pop       = out_valid & out_ready;
  assign push      = cache_hit & ~flush & ~pending & (~full | pop);

  // Static predictor: backward branches and (optionally) JAL are taken.
  always_comb begin
    pred     = 1'b0;
    pred_off = 32'sd4;
    if (PRED_BR && cache_inst[6:2] == OPC_BRANCH && cache_inst[1:0] == 2'b11
        && cache_inst[31]) begin
      pred     = 1'b1;
      pred_off = imm_b(cache_inst);
    end else if (PRED_JAL && cache_inst[6:2] == OPC_JAL && cache_inst[1:0] == 2'b11) begin
      pred     = 1'b1;
      pred_off = imm_j(cache_inst);
    end
  end

  // Modulo-2^32 wrap is the intended behaviour.
  assign next_pc = fetch_addr + $unsigned(pred_off);

  assign push_entry = '{pc: fetch_addr, inst: cache_inst, pred: pred};

  // A flush without a hit cannot redirect yet: an outstanding refill must
  // complete on the old address, so the target is parked in dnpc_r.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_addr <= RESET_PC;
      pending    <= 1'b0;
      dnpc_r     <= '0;
    end else if (flush) begin
      if (cache_hit) begin
        fetch_addr <= dnpc;
        pending    <= 1'b0;
      end else begin
        pending    <= 1'b1;
        dnpc_r     <= dnpc;
      end
    end else if (pending) begin
      if (cache_hit) begin
        fetch_addr <= dnpc_r;
        pending    <= 1'b0;
      end
    end else if (push) begin
      fetch_addr <= next_pc;
    end
  end

  ifu_sync_fifo #(
    .T     (fq_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .data  (push_entry),
    .pop   (pop),
    .flush (flush),
    .head  (head_entry),
    .count (occupancy),
    .full  (full),
    .empty (empty)
  );

  assign out_pc   = head_entry.pc;
  assign out_inst = head_entry.inst;
  assign out_pred = head_entry.pred;

endmodule

// File: tb/tb_ifu_fetch_queue.sv
module tb_ifu_fetch_queue;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BEQ  = 32'hFE00_0EE3;
  localparam logic [31:0] JAL  = 32'h0100_006F;
  localparam logic [31:0] RPC  = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        cache_hit;
  logic [31:0] cache_inst;
  logic        jump_flush;
  logic [31:0] jump_dnpc;
  logic        cs_flush;
  logic [31:0] cs_dnpc;
  logic        out_ready;

  logic [31:0] fetch_addr_a, out_pc_a, out_inst_a;
  logic        out_valid_a, out_pred_a;
  logic [2:0]  occupancy_a;
  logic [31:0] fetch_addr_b, out_pc_b, out_inst_b;
  logic        out_valid_b, out_pred_b;
  logic [2:0]  occupancy_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  ifu_fetch_queue dut_a (
    .clock(clock), .reset(reset), .fetch_addr(fetch_addr_a),
    .cache_hit(cache_hit), .cache_inst(cache_inst),
    .jump_flush(jump_flush), .jump_dnpc(jump_dnpc),
    .cs_flush(cs_flush), .cs_dnpc(cs_dnpc),
    .out_ready(out_ready), .out_valid(out_valid_a), .out_pc(out_pc_a),
    .out_inst(out_inst_a), .out_pred(out_pred_a), .occupancy(occupancy_a)
  );

  ifu_fetch_queue #(.PRED_JAL(1'b0), .PRED_BR(1'b0)) dut_b (
    .clock(clock), .reset(reset), .fetch_addr(fetch_addr_b),
    .cache_hit(cache_hit), .cache_inst(cache_inst),
    .jump_flush(jump_flush), .jump_dnpc(jump_dnpc),
    .cs_flush(cs_flush), .cs_dnpc(cs_dnpc),
    .out_ready(out_ready), .out_valid(out_valid_b), .out_pc(out_pc_b),
    .out_inst(out_inst_b), .out_pred(out_pred_b), .occupancy(occupancy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cache_hit = 1'b0; cache_inst = NOP; out_ready = 1'b0;
    jump_flush = 1'b0; jump_dnpc = '0; cs_flush = 1'b0; cs_dnpc = '0;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_fetch", fetch_addr_a, RPC);
    chk("rst_occ", {29'd0, occupancy_a}, 32'd0);
    chk("rst_valid", {31'd0, out_valid_a}, 32'd0);
    chk("rst_pc", out_pc_a, 32'd0);
    chk("rst_inst", out_inst_a, 32'd0);
    chk("rst_pred", {31'd0, out_pred_a}, 32'd0);

    // Sustained streaming, one instruction per cycle
    cache_hit = 1'b1; out_ready = 1'b1;
    step();
    chk("s_valid0", {31'd0, out_valid_a}, 32'd1);
    chk("s_pc0", out_pc_a, RPC);
    chk("s_inst0", out_inst_a, NOP);
    chk("s_fetch0", fetch_addr_a, RPC + 32'd4);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("s_valid", {31'd0, out_valid_a}, 32'd1);
      chk("s_pc", out_pc_a, RPC + 32'(4 * k));
      chk("s_fetch", fetch_addr_a, RPC + 32'(4 * (k + 1)));
      chk("s_occ", {29'd0, occupancy_a}, 32'd1);
    end

    // Fill to full with decode stalled, then drain in order
    do_reset();
    cache_hit = 1'b1;
    for (int k = 1; k <= 6; k++) step();
    chk("full_occ", {29'd0, occupancy_a}, 32'd4);
    chk("full_fetch", fetch_addr_a, RPC + 32'h10);
    chk("full_head", out_pc_a, RPC);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("drain_pc", out_pc_a, RPC + 32'(4 * k));
      chk("drain_occ", {29'd0, occupancy_a}, 32'd4);
    end

    // Backward branch at 0x80000008
    do_reset();
    cache_hit = 1'b1; out_ready = 1'b1;
    step();
    step();
    chk("br_at", fetch_addr_a, RPC + 32'h8);
    cache_inst = BEQ;
    step();
    cache_inst = NOP; cache_hit = 1'b0;
    #1;
    chk("br_pc", out_pc_a, RPC + 32'h8);
    chk("br_inst", out_inst_a, BEQ);
    chk("br_pred_a", {31'd0, out_pred_a}, 32'd1);
    chk("br_next_a", fetch_addr_a, RPC + 32'h4);
    chk("br_pred_b", {31'd0, out_pred_b}, 32'd0);
    chk("br_next_b", fetch_addr_b, RPC + 32'hC);

    // JAL at reset PC
    do_reset();
    cache_hit = 1'b1; out_ready = 1'b1; cache_inst = JAL;
    step();
    cache_hit = 1'b0;
    #1;
    chk("jal_pc", out_pc_a, RPC);
    chk("jal_pred_a", {31'd0, out_pred_a}, 32'd1);
    chk("jal_next_a", fetch_addr_a, RPC + 32'h10);
    chk("jal_pred_b", {31'd0, out_pred_b}, 32'd0);
    chk("jal_next_b", fetch_addr_b, RPC + 32'h4);

    // Flush with hit while 3 entries are queued
    do_reset();
    cache_hit = 1'b1;
    step(); step(); step();
    chk("fl_occ3", {29'd0, occupancy_a}, 32'd3);
    jump_flush = 1'b1; jump_dnpc = 32'h8000_0100; out_ready = 1'b1;
    #1;
    chk("fl_mask", {31'd0, out_valid_a}, 32'd0);
    step();
    jump_flush = 1'b0;
    #1;
    chk("fl_occ0", {29'd0, occupancy_a}, 32'd0);
    chk("fl_fetch", fetch_addr_a, 32'h8000_0100);
    chk("fl_valid", {31'd0, out_valid_a}, 32'd0);
    out_ready = 1'b0;
    step();
    chk("fl_newpc", out_pc_a, 32'h8000_0100);
    chk("fl_newocc", {29'd0, occupancy_a}, 32'd1);

    // Flush without hit, later higher-priority flush, then hit
    do_reset();
    jump_flush = 1'b1; jump_dnpc = 32'h8000_0200;
    step();
    jump_flush = 1'b0;
    chk("pd_hold0", fetch_addr_a, RPC);
    step();
    chk("pd_hold1", fetch_addr_a, RPC);
    cs_flush = 1'b1; cs_dnpc = 32'h8000_0300;
    jump_flush = 1'b1; jump_dnpc = 32'h8000_0400;
    step();
    cs_flush = 1'b0; jump_flush = 1'b0;
    step();
    step();
    chk("pd_hold2", fetch_addr_a, RPC);
    chk("pd_occ", {29'd0, occupancy_a}, 32'd0);
    cache_hit = 1'b1;
    step();
    chk("pd_redir", fetch_addr_a, 32'h8000_0300);
    chk("pd_nopush", {29'd0, occupancy_a}, 32'd0);
    chk("pd_novalid", {31'd0, out_valid_a}, 32'd0);
    step();
    chk("pd_push_pc", out_pc_a, 32'h8000_0300);
    chk("pd_push_occ", {29'd0, occupancy_a}, 32'd1);

    // Reset while a redirect is pending
    cache_hit = 1'b0; jump_flush = 1'b1; jump_dnpc = 32'h8000_0500;
    step();
    jump_flush = 1'b0;
    chk("rp_hold", fetch_addr_a, 32'h8000_0304);
    reset = 1'b1;
    step();
    chk("rp_fetch", fetch_addr_a, RPC);
    chk("rp_occ", {29'd0, occupancy_a}, 32'd0);
    reset = 1'b0; cache_hit = 1'b1; out_ready = 1'b0;
    step();
    chk("rp_pc", out_pc_a, RPC);
    chk("rp_next", fetch_addr_a, RPC + 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
